// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle sequencer and its helpers.
package cpu_pkg;

    // Sequencer states; encodings are visible on the debug state port.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd7
    } state_e;

    localparam logic [31:0] PC_INCR         = 32'd4;
    localparam int unsigned JUMP_REGION_MSB = 31;
    localparam int unsigned JUMP_REGION_LSB = 28;

    // Word-scaled, sign-extended 16-bit branch offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/cpu_sequencer_pc_next_calc.sv
// Next-PC arithmetic: sequential, branch-relative and region-absolute jump.
module pc_next_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic        jump,
    input  logic        branch_taken,
    output logic [31:0] pc_next
);

    logic [31:0] pc_plus4;
    logic        unused_ir;

    // Opcode bits are consumed by the decode controller, not here.
    assign unused_ir = ^ir[31:26];

    // Jump beats branch; all sums wrap modulo 2^32.
    always_comb begin
        pc_plus4 = pc + PC_INCR;
        if (jump) begin
            pc_next = {pc_plus4[JUMP_REGION_MSB:JUMP_REGION_LSB], ir[25:0], 2'b00};
        end else if (branch_taken) begin
            pc_next = pc_plus4 + branch_offset(ir[15:0]);
        end else begin
            pc_next = pc_plus4;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> WB, with a
// fetch timeout that parks the core in a sticky FAULT state.
// imem handshake: imem_req is held high with a stable imem_addr until a cycle
// where imem_ready is high; that cycle transfers imem_rdata. imem_ready seen
// outside FETCH is ignored, and a request may be withdrawn only by reset.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic [3:0]  byte_w_en_in,
    output logic [3:0]  reg_byte_w_en,
    output logic        reg_wr_strobe,
    output logic        busy,
    output logic        fault,
    output logic [31:0] retired,
    output logic [2:0]  state
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(FETCH_TIMEOUT);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pcn_q, pcn_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic [3:0]  bwe_q, bwe_d;
    logic [31:0] retired_q, retired_d;
    logic        imem_req_q, imem_req_d;
    logic        strobe_q, strobe_d;
    logic        busy_q, busy_d;
    logic        fault_q, fault_d;
    logic [31:0] pc_next;

    pc_next_calc u_pc_next_calc (
        .pc           (pc_q),
        .ir           (ir_q),
        .jump         (jump),
        .branch_taken (branch_taken),
        .pc_next      (pc_next)
    );

    // Next-state, datapath-register and registered-output computation.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        pcn_d     = pcn_q;
        cnt_d     = cnt_q;
        bwe_d     = bwe_q;
        retired_d = retired_q;
        cnt_inc   = cnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    cnt_d   = 8'd0;
                    state_d = DECODE;
                end else if (cnt_inc == TIMEOUT_LIM) begin
                    cnt_d   = 8'd0;
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                // branch_taken is only valid now, so the target is captured.
                bwe_d   = byte_w_en_in;
                pcn_d   = pc_next;
                state_d = WB;
            end
            WB: begin
                pc_d      = pcn_q;
                retired_d = retired_q + 32'd1;
                state_d   = run ? FETCH : IDLE;
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase

        // Outputs are registered alongside the state they belong to.
        imem_req_d = (state_d == FETCH);
        strobe_d   = (state_d == WB);
        busy_d     = (state_d != IDLE) && (state_d != FAULT);
        fault_d    = fault_q || (state_d == FAULT);
    end

    // All sequencer state, with asynchronous abort on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'd0;
            pcn_q      <= RESET_PC;
            cnt_q      <= 8'd0;
            bwe_q      <= 4'd0;
            retired_q  <= 32'd0;
            imem_req_q <= 1'b0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            pcn_q      <= pcn_d;
            cnt_q      <= cnt_d;
            bwe_q      <= bwe_d;
            retired_q  <= retired_d;
            imem_req_q <= imem_req_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
        end
    end

    assign imem_req      = imem_req_q;
    assign imem_addr     = pc_q;
    assign ir            = ir_q;
    assign pc            = pc_q;
    assign reg_byte_w_en = bwe_q;
    assign reg_wr_strobe = strobe_q;
    assign busy          = busy_q;
    assign fault         = fault_q;
    assign retired       = retired_q;
    assign state         = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer and its next-PC helper.
module tb_cpu_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        jump;
    logic        branch_taken;
    logic [3:0]  byte_w_en_in;
    logic [3:0]  reg_byte_w_en;
    logic        reg_wr_strobe;
    logic        busy;
    logic        fault;
    logic [31:0] retired;
    logic [2:0]  state;

    logic [31:0] c_pc, c_ir, c_out;
    logic        c_jump, c_br;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_sequencer #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .ir            (ir),
        .pc            (pc),
        .jump          (jump),
        .branch_taken  (branch_taken),
        .byte_w_en_in  (byte_w_en_in),
        .reg_byte_w_en (reg_byte_w_en),
        .reg_wr_strobe (reg_wr_strobe),
        .busy          (busy),
        .fault         (fault),
        .retired       (retired),
        .state         (state)
    );

    pc_next_calc u_calc (
        .pc           (c_pc),
        .ir           (c_ir),
        .jump         (c_jump),
        .branch_taken (c_br),
        .pc_next      (c_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, pc, RST_PC);
        check({tag, "_ir"}, ir, 32'd0);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_strobe"}, 32'(reg_wr_strobe), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        check({tag, "_bwe"}, 32'(reg_byte_w_en), 32'd0);
        check({tag, "_retired"}, retired, 32'd0);
    endtask

    // Entered one step after the edge that put the core in FETCH; leaves it in WB.
    task automatic do_instr(input logic [31:0] word, input logic j, input logic b,
                            input logic [3:0] bwe, input int waits,
                            input logic [31:0] exp_pc, input logic [31:0] ret_before,
                            input logic drop_run);
        imem_ready = 1'b0;
        for (int k = 0; k < waits; k++) begin
            check("wait_addr", imem_addr, exp_pc);
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_state", 32'(state), 32'd1);
            step();
        end
        check("fetch_addr", imem_addr, exp_pc);
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_busy", 32'(busy), 32'd1);
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        // Ready with garbage outside FETCH must not disturb ir.
        imem_rdata = 32'hDEAD_BEEF;
        if (drop_run) run = 1'b0;
        check("dec_state", 32'(state), 32'd2);
        check("dec_ir", ir, word);
        check("dec_req", 32'(imem_req), 32'd0);
        check("dec_pc", pc, exp_pc);
        check("dec_fault", 32'(fault), 32'd0);
        jump         = j;
        branch_taken = b;
        byte_w_en_in = bwe;
        step();
        check("exec_state", 32'(state), 32'd3);
        check("exec_ir", ir, word);
        check("exec_strobe", 32'(reg_wr_strobe), 32'd0);
        step();
        jump         = 1'b0;
        branch_taken = 1'b0;
        byte_w_en_in = 4'd0;
        imem_ready   = 1'b0;
        check("wb_state", 32'(state), 32'd4);
        check("wb_strobe", 32'(reg_wr_strobe), 32'd1);
        check("wb_bwe", 32'(reg_byte_w_en), 32'(bwe));
        check("wb_retired", retired, ret_before);
    endtask

    initial begin
        rst_n        = 1'b0;
        run          = 1'b0;
        imem_ready   = 1'b0;
        imem_rdata   = 32'd0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        byte_w_en_in = 4'd0;

        // Next-PC arithmetic in isolation.
        c_pc = 32'h1000_0040; c_ir = 32'h0000_0123; c_jump = 1'b1; c_br = 1'b1; #1;
        check("calc_jump_wins", c_out, 32'h1000_048C);
        c_pc = 32'h0000_0100; c_ir = 32'h1000_FFFE; c_jump = 1'b0; c_br = 1'b1; #1;
        check("calc_branch_back", c_out, 32'h0000_00FC);
        c_pc = 32'hFFFF_FFFC; c_ir = 32'h0000_0000; c_jump = 1'b0; c_br = 1'b0; #1;
        check("calc_seq_wrap", c_out, 32'h0000_0000);
        c_pc = 32'hFFFF_FFF0; c_ir = 32'h0000_0010; c_jump = 1'b0; c_br = 1'b1; #1;
        check("calc_branch_wrap", c_out, 32'h0000_0034);
        c_pc = 32'hF000_0000; c_ir = 32'hFFFF_FFFF; c_jump = 1'b1; c_br = 1'b0; #1;
        check("calc_jump_region", c_out, 32'hFFFF_FFFC);

        // Reset values.
        #2;
        check_reset_outputs("rst");
        step();
        rst_n = 1'b1;
        run   = 1'b1;
        step();
        check("first_fetch_state", 32'(state), 32'd1);

        // I0: plain, zero-wait fetch at 0x100.
        do_instr(32'h2108_0001, 1'b0, 1'b0, 4'hF, 0, 32'h100, 32'd0, 1'b0);
        step();
        check("i0_next_state", 32'(state), 32'd1);
        check("i0_next_addr", imem_addr, 32'h104);
        check("i0_retired", retired, 32'd1);
        check("i0_strobe_off", 32'(reg_wr_strobe), 32'd0);

        // I1: 3 wait cycles, branch -2 words from 0x104 -> 0x100.
        do_instr(32'h1000_FFFE, 1'b0, 1'b1, 4'h3, 3, 32'h104, 32'd1, 1'b0);
        step();
        check("i1_next_addr", imem_addr, 32'h100);
        check("i1_retired", retired, 32'd2);

        // I2: branch -2 words from 0x100 -> 0xFC.
        do_instr(32'h1000_FFFE, 1'b0, 1'b1, 4'h1, 0, 32'h100, 32'd2, 1'b0);
        step();
        check("i2_next_addr", imem_addr, 32'h0FC);
        check("i2_retired", retired, 32'd3);

        // I3: ready on the last legal wait cycle; jump and branch both high.
        do_instr(32'h0800_0123, 1'b1, 1'b1, 4'h8, 15, 32'h0FC, 32'd3, 1'b0);
        step();
        check("i3_next_addr", imem_addr, 32'h48C);
        check("i3_retired", retired, 32'd4);
        check("i3_no_fault", 32'(fault), 32'd0);

        // I4: run dropped in DECODE; instruction completes, then IDLE.
        do_instr(32'h2108_0002, 1'b0, 1'b0, 4'h4, 0, 32'h48C, 32'd4, 1'b1);
        step();
        check("i4_idle_state", 32'(state), 32'd0);
        check("i4_idle_req", 32'(imem_req), 32'd0);
        check("i4_idle_busy", 32'(busy), 32'd0);
        check("i4_retired", retired, 32'd5);
        check("i4_pc", pc, 32'h490);
        step();
        check("i4_still_idle", 32'(state), 32'd0);
        check("i4_still_no_req", 32'(imem_req), 32'd0);

        // Fetch timeout: 16 FETCH cycles without ready.
        run = 1'b1;
        step();
        imem_ready = 1'b0;
        for (int k = 0; k < 15; k++) begin
            check("to_fetch_state", 32'(state), 32'd1);
            check("to_fetch_req", 32'(imem_req), 32'd1);
            step();
        end
        check("to_last_fetch", 32'(state), 32'd1);
        step();
        check("to_fault_state", 32'(state), 32'd7);
        check("to_fault_flag", 32'(fault), 32'd1);
        check("to_fault_req", 32'(imem_req), 32'd0);
        check("to_fault_busy", 32'(busy), 32'd0);

        // FAULT ignores run and ready.
        run = 1'b0; step();
        run = 1'b1; imem_ready = 1'b1; step();
        run = 1'b0; step();
        check("fault_sticky_state", 32'(state), 32'd7);
        check("fault_sticky_flag", 32'(fault), 32'd1);
        check("fault_pc_frozen", pc, 32'h490);
        check("fault_strobe", 32'(reg_wr_strobe), 32'd0);
        imem_ready = 1'b0;

        // Reset pulse clears the fault.
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("fault_rst");
        step();
        rst_n = 1'b1;
        run   = 1'b1;
        step();
        check("rerun_req", 32'(imem_req), 32'd1);
        check("rerun_addr", imem_addr, RST_PC);

        // Reset mid-FETCH drops the request without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midfetch_rst");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
